// File: rtl/serial_out_piso_pkg.sv
// Shared types and helpers for the serial_out PISO transmitter.
package serial_out_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_out_piso_if.sv
// Word handshake, abort and serial-line bundle for serial_out_piso.
interface serial_out_piso_if #(
  parameter int WIDTH = 8
);
  logic             abort;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             sout;
  logic             sout_en;
  logic             busy;
  logic             done;

  modport master (
    output abort, in_valid, in_data,
    input  in_ready, sout, sout_en, busy, done
  );

  modport slave (
    input  abort, in_valid, in_data,
    output in_ready, sout, sout_en, busy, done
  );
endinterface

// File: rtl/serial_out_bit_timer.sv
// Per-bit cycle counter; bit_end marks the final clock of each bit period.
module serial_out_bit_timer
  import serial_out_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic r_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_bit_end
);
  localparam int CW = cnt_w(BIT_CYCLES);
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] r_cyc_cnt;
  logic          w_bit_end;

  // A single-cycle bit always ends immediately, independent of the counter.
  assign w_bit_end = (BIT_CYCLES == 1) ? 1'b1 : (r_cyc_cnt == CYC_LAST);
  assign o_bit_end = w_bit_end;

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      r_cyc_cnt <= '0;
    end else if (i_clr) begin
      r_cyc_cnt <= '0;
    end else if (i_en) begin
      if (w_bit_end) r_cyc_cnt <= '0;
      else           r_cyc_cnt <= r_cyc_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/serial_out_piso.sv
// Parallel-in/serial-out transmitter: valid/ready word intake, bit-timed
// shifting onto sout, back-to-back frames and synchronous abort.
module serial_out_piso
  import serial_out_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input logic             clk,
  input logic             r_n,
  serial_out_piso_if.slave bus
);
  localparam int BW = cnt_w(WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  state_t           r_state;
  logic [BW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic             r_sout;
  logic             r_sout_en;
  logic             r_busy;
  logic             r_done;

  logic             w_bit_end;
  logic             w_last_cycle;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_first_bit;
  logic [WIDTH-1:0] w_shifted;

  assign w_last_cycle = (r_state == SHIFT) && (r_bit_cnt == BIT_LAST) && w_bit_end;
  // in_ready is the only combinational output; gating with r_n keeps it low in reset.
  assign w_in_ready   = r_n && !bus.abort && ((r_state == IDLE) || w_last_cycle);
  assign w_accept     = bus.in_valid && w_in_ready;
  assign w_first_bit  = MSB_FIRST ? bus.in_data[WIDTH-1] : bus.in_data[0];
  assign w_shifted    = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0} : {1'b0, r_shreg[WIDTH-1:1]};

  serial_out_bit_timer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_bit_timer (
    .clk       (clk),
    .r_n       (r_n),
    .i_clr     (bus.abort || w_accept),
    .i_en      (r_state == SHIFT),
    .o_bit_end (w_bit_end)
  );

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_sout    <= IDLE_LEVEL;
      r_sout_en <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (bus.abort) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_sout    <= IDLE_LEVEL;
      r_sout_en <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_last_cycle;
      if (w_accept) begin
        r_state   <= SHIFT;
        r_bit_cnt <= '0;
        r_shreg   <= bus.in_data;
        r_sout    <= w_first_bit;
        r_sout_en <= 1'b1;
        r_busy    <= 1'b1;
      end else if (w_last_cycle) begin
        r_state   <= IDLE;
        r_bit_cnt <= '0;
        r_sout    <= IDLE_LEVEL;
        r_sout_en <= 1'b0;
        r_busy    <= 1'b0;
      end else if ((r_state == SHIFT) && w_bit_end) begin
        // Next bit comes from the shifted image so sout stays registered.
        r_bit_cnt <= r_bit_cnt + 1'b1;
        r_shreg   <= w_shifted;
        r_sout    <= MSB_FIRST ? w_shifted[WIDTH-1] : w_shifted[0];
      end
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.sout     = r_sout;
  assign bus.sout_en  = r_sout_en;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
endmodule

// File: tb/tb_serial_out_piso.sv
// Directed bench for serial_out_piso: MSB-first single-cycle bits and
// LSB-first three-cycle bits, back-to-back, abort and async reset.
module tb_serial_out_piso;
  logic clk;
  logic r_n;
  int   tests_run;
  int   tests_failed;

  serial_out_piso_if #(.WIDTH(8)) bus_a ();
  serial_out_piso_if #(.WIDTH(8)) bus_b ();

  serial_out_piso #(
    .WIDTH(8), .BIT_CYCLES(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)
  ) dut_a (
    .clk (clk),
    .r_n (r_n),
    .bus (bus_a.slave)
  );

  serial_out_piso #(
    .WIDTH(8), .BIT_CYCLES(3), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)
  ) dut_b (
    .clk (clk),
    .r_n (r_n),
    .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] word;
    tests_run    = 0;
    tests_failed = 0;
    r_n            = 1'b0;
    bus_a.abort    = 1'b0;
    bus_a.in_valid = 1'b0;
    bus_a.in_data  = 8'h00;
    bus_b.abort    = 1'b0;
    bus_b.in_valid = 1'b0;
    bus_b.in_data  = 8'h00;

    #7;
    chk("rst_sout",     bus_a.sout,     1'b1);
    chk("rst_sout_en",  bus_a.sout_en,  1'b0);
    chk("rst_busy",     bus_a.busy,     1'b0);
    chk("rst_done",     bus_a.done,     1'b0);
    chk("rst_in_ready", bus_a.in_ready, 1'b0);
    step();
    r_n = 1'b1;
    #1;
    chk("idle_in_ready", bus_a.in_ready, 1'b1);

    // 0xA5, MSB first, one clock per bit
    word = 8'hA5;
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = word;
    step();
    bus_a.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("a5_bit%0d", i), bus_a.sout, word[7-i]);
      chk($sformatf("a5_en%0d", i),  bus_a.sout_en, 1'b1);
      chk($sformatf("a5_done%0d", i), bus_a.done, 1'b0);
      step();
    end
    chk("a5_done",    bus_a.done,    1'b1);
    chk("a5_idle",    bus_a.sout,    1'b1);
    chk("a5_busy",    bus_a.busy,    1'b0);
    chk("a5_en_off",  bus_a.sout_en, 1'b0);
    step();
    chk("a5_done_pulse", bus_a.done, 1'b0);

    // 0x01, LSB first, three clocks per bit
    bus_b.in_valid = 1'b1;
    bus_b.in_data  = 8'h01;
    step();
    bus_b.in_valid = 1'b0;
    for (int i = 0; i < 24; i++) begin
      chk($sformatf("b01_cyc%0d", i + 1), bus_b.sout, (i < 3) ? 1'b1 : 1'b0);
      chk($sformatf("b01_en%0d", i + 1),  bus_b.sout_en, 1'b1);
      step();
    end
    chk("b01_done",   bus_b.done,    1'b1);
    chk("b01_en_off", bus_b.sout_en, 1'b0);
    chk("b01_busy",   bus_b.busy,    1'b0);

    // Back-to-back 0xFF then 0x00 with in_valid held
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 8'hFF;
    step();
    bus_a.in_data  = 8'h00;
    #1;
    chk("b2b_ready_c1", bus_a.in_ready, 1'b0);
    for (int i = 1; i < 8; i++) step();
    chk("b2b_ready_c8", bus_a.in_ready, 1'b1);
    chk("b2b_sout_c8",  bus_a.sout,     1'b1);
    step();
    bus_a.in_valid = 1'b0;
    chk("b2b_sout_c9", bus_a.sout,    1'b0);
    chk("b2b_done_c9", bus_a.done,    1'b1);
    chk("b2b_busy_c9", bus_a.busy,    1'b1);
    chk("b2b_en_c9",   bus_a.sout_en, 1'b1);
    step();
    chk("b2b_done_c10", bus_a.done, 1'b0);
    chk("b2b_sout_c10", bus_a.sout, 1'b0);
    for (int i = 10; i < 17; i++) step();
    chk("b2b_done_c17", bus_a.done, 1'b1);
    chk("b2b_busy_c17", bus_a.busy, 1'b0);
    step();

    // Abort at cycle 4 of a 0xFF frame, with in_valid raised alongside
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 8'hFF;
    step();
    bus_a.in_valid = 1'b0;
    for (int i = 1; i < 4; i++) step();
    bus_a.abort    = 1'b1;
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 8'h00;
    #1;
    chk("abt_ready_c4", bus_a.in_ready, 1'b0);
    step();
    bus_a.abort    = 1'b0;
    bus_a.in_valid = 1'b0;
    chk("abt_sout_c5", bus_a.sout,    1'b1);
    chk("abt_en_c5",   bus_a.sout_en, 1'b0);
    chk("abt_busy_c5", bus_a.busy,    1'b0);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("abt_nodone%0d", i), bus_a.done, 1'b0);
      step();
    end

    // Abort while idle must also swallow a valid word
    bus_a.abort    = 1'b1;
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 8'h55;
    #1;
    chk("abt_idle_ready", bus_a.in_ready, 1'b0);
    step();
    bus_a.abort    = 1'b0;
    bus_a.in_valid = 1'b0;
    chk("abt_idle_busy", bus_a.busy,    1'b0);
    chk("abt_idle_en",   bus_a.sout_en, 1'b0);
    step();

    // Asynchronous reset mid-frame
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 8'h00;
    step();
    step();
    step();
    chk("ar_busy_pre", bus_a.busy, 1'b1);
    #2;
    r_n = 1'b0;
    #1;
    chk("ar_sout",     bus_a.sout,     1'b1);
    chk("ar_en",       bus_a.sout_en,  1'b0);
    chk("ar_busy",     bus_a.busy,     1'b0);
    chk("ar_in_ready", bus_a.in_ready, 1'b0);
    step();
    chk("ar_hold_busy", bus_a.busy, 1'b0);
    r_n = 1'b1;
    word = 8'h3C;
    bus_a.in_data = word;
    #1;
    chk("ar_rel_ready", bus_a.in_ready, 1'b1);
    step();
    bus_a.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("3c_bit%0d", i), bus_a.sout, word[7-i]);
      chk($sformatf("3c_en%0d", i),  bus_a.sout_en, 1'b1);
      step();
    end
    chk("3c_done", bus_a.done, 1'b1);
    chk("3c_busy", bus_a.busy, 1'b0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
